// File: rtl/ex_mem_stage.sv
// ex_mem_stage
// Execute stage and EX/MEM pipeline register of the five-stage RV32 core.
// Applies operand forwarding to the ID/EX operands. Computes ALU, branch,
// jump and AUIPC results. An iterative unit handles MUL/MULHU/DIVU/REMU,
// one step per cycle, and stalls the front end while it is working.
//
// Ports
//   clk, reset                      clock, asynchronous active-high reset
//   pc_in, instr_in, read_data1_in,
//   read_data2_in, imm_in, rd_in    ID/EX datapath
//   alu_ctrl_in                     operation code (0..F)
//   mem_read_in .. auipc_in         ID/EX control bits
//   fwd_a_sel, fwd_b_sel            00/11 register file, 01 EX/MEM, 10 MEM/WB
//   ex_mem_fwd_data, mem_wb_fwd_data forwarding sources
//   alu_result_out, write_data_out,
//   rd_out, funct3_out, *_out       registered EX/MEM outputs
//   redirect_valid, redirect_pc     combinational taken branch / jump
//   md_stall                        combinational; holds PC, IF/ID and ID/EX
module ex_mem_stage #(
  parameter int XLEN      = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] read_data1_in,
  input  logic [XLEN-1:0] read_data2_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [4:0]      rd_in,
  input  logic [3:0]      alu_ctrl_in,
  input  logic            mem_read_in,
  input  logic            mem_write_in,
  input  logic            reg_write_in,
  input  logic            mem_to_reg_in,
  input  logic            alu_src_in,
  input  logic            branch_in,
  input  logic            jump_in,
  input  logic            auipc_in,
  input  logic [1:0]      fwd_a_sel,
  input  logic [1:0]      fwd_b_sel,
  input  logic [XLEN-1:0] ex_mem_fwd_data,
  input  logic [XLEN-1:0] mem_wb_fwd_data,
  output logic [XLEN-1:0] alu_result_out,
  output logic [XLEN-1:0] write_data_out,
  output logic [4:0]      rd_out,
  output logic [2:0]      funct3_out,
  output logic            mem_read_out,
  output logic            mem_write_out,
  output logic            reg_write_out,
  output logic            mem_to_reg_out,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            md_stall
);

  localparam int CW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Multiply/divide sub-operation, captured when the op starts
  localparam logic [1:0] MD_MUL   = 2'd0;
  localparam logic [1:0] MD_MULHU = 2'd1;
  localparam logic [1:0] MD_DIVU  = 2'd2;
  localparam logic [1:0] MD_REMU  = 2'd3;

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b_fwd;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_res;
  logic [4:0]      shamt;
  logic [2:0]      funct3;
  logic            is_jalr;
  logic            is_md;
  logic            taken;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] ex_result;

  logic [1:0]      state_reg;
  logic [CW-1:0]   count_reg;
  logic [XLEN-1:0] acc_hi_reg;   // product high half / partial remainder
  logic [XLEN-1:0] acc_lo_reg;   // multiplier bits / dividend bits -> quotient
  logic [XLEN-1:0] md_b_reg;     // multiplicand / divisor
  logic [1:0]      md_op_reg;
  logic [1:0]      md_op_next;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN+1:0] div_diff;
  logic            div_ge;
  logic [XLEN-1:0] md_result;

  // Instruction bits outside funct3/opcode are not needed here
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr_in[XLEN-1:15], instr_in[11:7]};

  assign funct3  = instr_in[14:12];
  assign is_jalr = (instr_in[6:0] == 7'b1100111);
  assign is_md   = (alu_ctrl_in >= 4'hB) && (alu_ctrl_in <= 4'hE);

  // Operand forwarding; select 11 falls back to the register file
  always_comb begin
    op_a = read_data1_in;
    case (fwd_a_sel)
      2'b01:   op_a = ex_mem_fwd_data;
      2'b10:   op_a = mem_wb_fwd_data;
      default: op_a = read_data1_in;
    endcase
  end

  always_comb begin
    op_b_fwd = read_data2_in;
    case (fwd_b_sel)
      2'b01:   op_b_fwd = ex_mem_fwd_data;
      2'b10:   op_b_fwd = mem_wb_fwd_data;
      default: op_b_fwd = read_data2_in;
    endcase
  end

  assign alu_b = alu_src_in ? imm_in : op_b_fwd;
  assign shamt = alu_b[4:0];

  // Single-cycle ALU; codes B..E are handled by the iterative unit,
  // so they simply fall into the ADD default here.
  always_comb begin
    alu_res = op_a + alu_b;
    case (alu_ctrl_in)
      4'h1: alu_res = op_a - alu_b;
      4'h2: alu_res = op_a & alu_b;
      4'h3: alu_res = op_a | alu_b;
      4'h4: alu_res = op_a ^ alu_b;
      4'h5: alu_res = op_a << shamt;
      4'h6: alu_res = op_a >> shamt;
      4'h7: alu_res = XLEN'($signed(op_a) >>> shamt);
      4'h8: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b_fwd_or_imm()))};
      4'h9: alu_res = {{(XLEN-1){1'b0}}, (op_a < alu_b)};
      4'hA: alu_res = alu_b;
      default: ;
    endcase
  end

  function automatic logic [XLEN-1:0] op_b_fwd_or_imm();
    return alu_b;
  endfunction

  // Branch compare uses the forwarded register operands, never the immediate
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = (op_a == op_b_fwd);
      3'b001:  taken = (op_a != op_b_fwd);
      3'b100:  taken = ($signed(op_a) <  $signed(op_b_fwd));
      3'b101:  taken = ($signed(op_a) >= $signed(op_b_fwd));
      3'b110:  taken = (op_a <  op_b_fwd);
      3'b111:  taken = (op_a >= op_b_fwd);
      default: taken = 1'b0;
    endcase
  end

  assign jalr_sum       = op_a + imm_in;
  assign redirect_valid = jump_in | (branch_in & taken);
  assign redirect_pc    = (jump_in && is_jalr) ? {jalr_sum[XLEN-1:1], 1'b0}
                                               : (pc_in + imm_in);

  // Shift-add multiply step: add multiplicand when the low multiplier bit is
  // set, then shift the {hi, lo} pair right, catching the carry in the top.
  assign mul_sum = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, md_b_reg} : '0);

  // Restoring divide step: shift the next dividend bit into the remainder and
  // subtract the divisor if it fits. A zero divisor always "fits", which
  // naturally yields an all-ones quotient and a remainder equal to the dividend.
  assign div_shift = {acc_hi_reg, acc_lo_reg[XLEN-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b0, md_b_reg};
  assign div_ge    = ~div_diff[XLEN+1];

  always_comb begin
    md_op_next = MD_MUL;
    case (alu_ctrl_in)
      4'hC:    md_op_next = MD_MULHU;
      4'hD:    md_op_next = MD_DIVU;
      4'hE:    md_op_next = MD_REMU;
      default: md_op_next = MD_MUL;
    endcase
  end

  always_comb begin
    md_result = acc_lo_reg;
    case (md_op_reg)
      MD_MULHU, MD_REMU: md_result = acc_hi_reg;
      default:           md_result = acc_lo_reg;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      count_reg  <= '0;
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      md_b_reg   <= '0;
      md_op_reg  <= MD_MUL;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (is_md) begin
            state_reg  <= ST_BUSY;
            count_reg  <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= op_a;
            md_b_reg   <= alu_b;
            md_op_reg  <= md_op_next;
          end
        end
        ST_BUSY: begin
          if (md_op_reg[1]) begin
            acc_hi_reg <= div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            acc_lo_reg <= {acc_lo_reg[XLEN-2:0], div_ge};
          end else begin
            acc_hi_reg <= mul_sum[XLEN:1];
            acc_lo_reg <= {mul_sum[0], acc_lo_reg[XLEN-1:1]};
          end
          count_reg <= count_reg + 1'b1;
          if (count_reg == CW'(MD_CYCLES - 1)) begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Stall is forced low while reset is held so the front end is released
  // even if an M-extension op is still sitting in ID/EX.
  assign md_stall = ~reset & (((state_reg == ST_IDLE) & is_md) | (state_reg == ST_BUSY));

  always_comb begin
    ex_result = alu_res;
    if (state_reg == ST_DONE) begin
      ex_result = md_result;
    end else if (jump_in) begin
      ex_result = pc_in + XLEN'(4);
    end else if (auipc_in) begin
      ex_result = pc_in + imm_in;
    end
  end

  // EX/MEM register; a stalled cycle inserts a bubble (controls cleared)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_result_out <= '0;
      write_data_out <= '0;
      funct3_out     <= '0;
      rd_out         <= '0;
      mem_read_out   <= 1'b0;
      mem_write_out  <= 1'b0;
      reg_write_out  <= 1'b0;
      mem_to_reg_out <= 1'b0;
    end else begin
      alu_result_out <= ex_result;
      write_data_out <= op_b_fwd;
      funct3_out     <= funct3;
      if (md_stall) begin
        rd_out         <= '0;
        mem_read_out   <= 1'b0;
        mem_write_out  <= 1'b0;
        reg_write_out  <= 1'b0;
        mem_to_reg_out <= 1'b0;
      end else begin
        rd_out         <= rd_in;
        mem_read_out   <= mem_read_in;
        mem_write_out  <= mem_write_in;
        reg_write_out  <= reg_write_in;
        mem_to_reg_out <= mem_to_reg_in;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage
// Randomized and directed checks of ex_mem_stage against a behavioural model
// that computes results with plain arithmetic (64-bit products, / and %).
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in, instr_in, read_data1_in, read_data2_in, imm_in;
  logic [4:0]  rd_in;
  logic [3:0]  alu_ctrl_in;
  logic        mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in;
  logic        alu_src_in, branch_in, jump_in, auipc_in;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] ex_mem_fwd_data, mem_wb_fwd_data;
  logic [31:0] alu_result_out, write_data_out;
  logic [4:0]  rd_out;
  logic [2:0]  funct3_out;
  logic        mem_read_out, mem_write_out, reg_write_out, mem_to_reg_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        md_stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.XLEN(32), .MD_CYCLES(32)) dut (
    .clk(clk), .reset(reset),
    .pc_in(pc_in), .instr_in(instr_in),
    .read_data1_in(read_data1_in), .read_data2_in(read_data2_in),
    .imm_in(imm_in), .rd_in(rd_in), .alu_ctrl_in(alu_ctrl_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .alu_src_in(alu_src_in), .branch_in(branch_in), .jump_in(jump_in),
    .auipc_in(auipc_in), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .ex_mem_fwd_data(ex_mem_fwd_data), .mem_wb_fwd_data(mem_wb_fwd_data),
    .alu_result_out(alu_result_out), .write_data_out(write_data_out),
    .rd_out(rd_out), .funct3_out(funct3_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .md_stall(md_stall)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] pick_src(input logic [1:0] sel, input logic [31:0] rf);
    if (sel == 2'b01) return ex_mem_fwd_data;
    if (sel == 2'b10) return mem_wb_fwd_data;
    return rf;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    int unsigned sh;
    sh   = b % 32;
    prod = {32'd0, a} * {32'd0, b};
    case (op)
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return a << sh;
      4'h6: return a >> sh;
      4'h7: return 32'($signed(a) >>> sh);
      4'h8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h9: return (a < b) ? 32'd1 : 32'd0;
      4'hA: return b;
      4'hB: return prod[31:0];
      4'hC: return prod[63:32];
      4'hD: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'hE: return (b == 0) ? a : a % b;
      default: return a + b;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return $signed(a) < $signed(b);
      3'b101: return $signed(a) >= $signed(b);
      3'b110: return a < b;
      3'b111: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ctrl_pack(input logic [4:0] rd, input logic rw, input logic mr,
                                            input logic mw, input logic m2r);
    return {23'd0, rd, rw, mr, mw, m2r};
  endfunction

  task automatic clear_inputs();
    pc_in = 0; instr_in = 0; read_data1_in = 0; read_data2_in = 0; imm_in = 0;
    rd_in = 0; alu_ctrl_in = 0; mem_read_in = 0; mem_write_in = 0; reg_write_in = 0;
    mem_to_reg_in = 0; alu_src_in = 0; branch_in = 0; jump_in = 0; auipc_in = 0;
    fwd_a_sel = 0; fwd_b_sel = 0; ex_mem_fwd_data = 0; mem_wb_fwd_data = 0;
  endtask

  // Inputs already driven (at a negedge); checks combinational outputs now and
  // registered outputs after the next rising edge, then returns at a negedge.
  task automatic single_op(input string name);
    logic [31:0] a, bf, bsel, exp_res, exp_tgt, exp_ctrl;
    logic        exp_valid;
    logic [2:0]  f3;
    f3   = instr_in[14:12];
    a    = pick_src(fwd_a_sel, read_data1_in);
    bf   = pick_src(fwd_b_sel, read_data2_in);
    bsel = alu_src_in ? imm_in : bf;
    if (jump_in)       exp_res = pc_in + 32'd4;
    else if (auipc_in) exp_res = pc_in + imm_in;
    else               exp_res = ref_alu(alu_ctrl_in, a, bsel);
    exp_valid = jump_in || (branch_in && ref_taken(f3, a, bf));
    if (jump_in && instr_in[6:0] == 7'b1100111) exp_tgt = (a + imm_in) & 32'hFFFF_FFFE;
    else                                       exp_tgt = pc_in + imm_in;
    exp_ctrl = ctrl_pack(rd_in, reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in);
    #1;
    check_val({name, ".stall"}, {31'd0, md_stall}, 32'd0);
    check_val({name, ".rvalid"}, {31'd0, redirect_valid}, {31'd0, exp_valid});
    if (exp_valid) check_val({name, ".rpc"}, redirect_pc, exp_tgt);
    @(posedge clk); #1;
    check_val({name, ".result"}, alu_result_out, exp_res);
    check_val({name, ".wdata"}, write_data_out, bf);
    check_val({name, ".ctrl"}, ctrl_pack(rd_out, reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out), exp_ctrl);
    check_val({name, ".funct3"}, {29'd0, funct3_out}, {29'd0, f3});
    $display("txn %s op=%h a=%08h b=%08h res=%08h redirect=%0d", name, alu_ctrl_in, a, bsel, alu_result_out, exp_valid);
    @(negedge clk);
  endtask

  // Multiply/divide: stall must last MD_CYCLES+1 cycles with bubbles
  // registered, then the result lands with the original control bits.
  task automatic md_op(input string name);
    logic [31:0] a, bsel, exp_res, exp_ctrl;
    int stalls;
    bit done;
    a        = pick_src(fwd_a_sel, read_data1_in);
    bsel     = alu_src_in ? imm_in : pick_src(fwd_b_sel, read_data2_in);
    exp_res  = ref_alu(alu_ctrl_in, a, bsel);
    exp_ctrl = ctrl_pack(rd_in, reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in);
    stalls   = 0;
    done     = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      #1;
      if (!md_stall) begin
        done = 1;
      end else begin
        stalls++;
        @(posedge clk); #1;
        check_val({name, ".bubble"}, ctrl_pack(rd_out, reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out), 32'd0);
        @(negedge clk);
      end
    end
    if (!done) check_val({name, ".timeout"}, 32'd1, 32'd0);
    check_val({name, ".stalls"}, 32'(stalls), 32'd33);
    @(posedge clk); #1;
    check_val({name, ".result"}, alu_result_out, exp_res);
    check_val({name, ".ctrl"}, ctrl_pack(rd_out, reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out), exp_ctrl);
    $display("txn %s op=%h a=%08h b=%08h res=%08h stalls=%0d", name, alu_ctrl_in, a, bsel, alu_result_out, stalls);
    @(negedge clk);
    alu_ctrl_in = 4'h0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_val("rst.result", alu_result_out, 32'd0);
    check_val("rst.ctrl", ctrl_pack(rd_out, reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out), 32'd0);
    check_val("rst.stall", {31'd0, md_stall}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // ---- directed cases ----
    clear_inputs(); read_data1_in = 5; read_data2_in = 7; rd_in = 5'd3; reg_write_in = 1;
    single_op("add");
    clear_inputs(); read_data1_in = 5; read_data2_in = 7; fwd_a_sel = 2'b01; ex_mem_fwd_data = 100;
    rd_in = 5'd4; reg_write_in = 1;
    single_op("add_fwd");
    clear_inputs(); read_data1_in = 32'h8000_0000; read_data2_in = 4; alu_ctrl_in = 4'h7;
    single_op("sra");
    clear_inputs(); read_data1_in = 1; read_data2_in = 32'hFFFF_FFFF; alu_ctrl_in = 4'h9;
    single_op("sltu");
    clear_inputs(); read_data1_in = 1; read_data2_in = 32'hFFFF_FFFF; alu_ctrl_in = 4'h8;
    single_op("slt");
    clear_inputs(); read_data1_in = 32'hFFFF_FFFF; read_data2_in = 1; pc_in = 32'h100; imm_in = 32'h20;
    instr_in = 32'h0000_4063; branch_in = 1;
    single_op("blt");
    clear_inputs(); read_data1_in = 32'h203; imm_in = 1; pc_in = 32'h40; instr_in = 32'h0000_0067;
    jump_in = 1; alu_src_in = 1; rd_in = 5'd1; reg_write_in = 1;
    single_op("jalr");
    clear_inputs(); read_data2_in = 3; fwd_a_sel = 2'b11; fwd_b_sel = 2'b11; ex_mem_fwd_data = 9;
    mem_wb_fwd_data = 11; read_data1_in = 2;
    single_op("fwd11");
    clear_inputs();
    single_op("bubble");

    clear_inputs(); read_data1_in = 32'hFFFF_FFFF; read_data2_in = 2; alu_ctrl_in = 4'hB;
    rd_in = 5'd7; reg_write_in = 1;
    md_op("mul");
    clear_inputs(); read_data1_in = 32'hFFFF_FFFF; read_data2_in = 2; alu_ctrl_in = 4'hC;
    rd_in = 5'd8; reg_write_in = 1;
    md_op("mulhu");
    clear_inputs(); read_data1_in = 100; read_data2_in = 0; alu_ctrl_in = 4'hD; rd_in = 5'd9; reg_write_in = 1;
    md_op("divu0");
    clear_inputs(); read_data1_in = 100; read_data2_in = 0; alu_ctrl_in = 4'hE; rd_in = 5'd9; reg_write_in = 1;
    md_op("remu0");
    clear_inputs(); read_data1_in = 100; read_data2_in = 7; alu_ctrl_in = 4'hD; rd_in = 5'd10; reg_write_in = 1;
    md_op("divu");
    clear_inputs(); read_data1_in = 100; read_data2_in = 7; alu_ctrl_in = 4'hE; rd_in = 5'd10; reg_write_in = 1;
    md_op("remu");

    // ---- reset in the middle of a multiply (BUSY count 10) ----
    clear_inputs(); read_data1_in = 32'hFFFF_FFFF; read_data2_in = 2; alu_ctrl_in = 4'hB;
    instr_in = 32'h0000_7000; rd_in = 5'd5; reg_write_in = 1;
    repeat (11) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_val("midrst.result", alu_result_out, 32'd0);
    check_val("midrst.wdata", write_data_out, 32'd0);
    check_val("midrst.funct3", {29'd0, funct3_out}, 32'd0);
    check_val("midrst.ctrl", ctrl_pack(rd_out, reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out), 32'd0);
    check_val("midrst.stall", {31'd0, md_stall}, 32'd0);
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
    read_data1_in = 40; read_data2_in = 2; rd_in = 5'd6; reg_write_in = 1;
    single_op("add_after_rst");

    // ---- randomized single-cycle operations ----
    for (int i = 0; i < 60; i++) begin
      int k, kind;
      clear_inputs();
      pc_in = $urandom & 32'hFFFF_FFFC;
      instr_in = $urandom;
      if ($urandom_range(0, 3) == 0) instr_in[6:0] = 7'b1100111;
      read_data1_in = $urandom; read_data2_in = $urandom;
      if ($urandom_range(0, 5) == 0) read_data2_in = read_data1_in;
      ex_mem_fwd_data = $urandom; mem_wb_fwd_data = $urandom; imm_in = $urandom;
      fwd_a_sel = 2'($urandom_range(0, 3)); fwd_b_sel = 2'($urandom_range(0, 3));
      alu_src_in = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 11);
      alu_ctrl_in = (k <= 10) ? 4'(k) : 4'hF;
      kind = $urandom_range(0, 3);
      branch_in = (kind == 1); jump_in = (kind == 2); auipc_in = (kind == 3);
      rd_in = 5'($urandom); reg_write_in = 1'($urandom); mem_read_in = 1'($urandom);
      mem_write_in = 1'($urandom); mem_to_reg_in = 1'($urandom);
      single_op($sformatf("rnd%0d", i));
    end

    // ---- randomized multiply/divide ----
    for (int i = 0; i < 8; i++) begin
      int pick;
      clear_inputs();
      alu_ctrl_in = 4'(11 + $urandom_range(0, 3));
      read_data1_in = $urandom; ex_mem_fwd_data = $urandom; mem_wb_fwd_data = $urandom;
      pick = $urandom_range(0, 3);
      read_data2_in = (pick == 0) ? 32'd0 : (pick == 1) ? 32'($urandom_range(1, 50)) : $urandom;
      fwd_a_sel = 2'($urandom_range(0, 3));
      rd_in = 5'($urandom_range(1, 31)); reg_write_in = 1; mem_to_reg_in = 1'($urandom);
      md_op($sformatf("rndmd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
